// File: rtl/disp_sched.sv
`default_nettype none
// ============================================================================
// Module   : disp_sched
// Brief    : Two-source round-robin scheduler for a 4-digit multiplexed
//            display. Grants one word at a time and holds it on screen for
//            HOLD_FRAMES full scan frames. A free-running prescaler produces
//            the digit scan tick.
//            Optional macro DISP_SCHED_BLANK_EN inserts a one-tick all-ones
//            blank period between consecutive words.
// Revision : 1.0  initial release
// ============================================================================
module disp_sched #(
    parameter int PRESCALE    = 50000,
    parameter int HOLD_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [15:0] req0_data,
    input  logic        req1_valid,
    input  logic [15:0] req1_data,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] disp_data,
    output logic        disp_src,
    output logic        disp_busy,
    output logic        scan_tick
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int HW = 10;

    localparam logic [PW-1:0] c_PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [HW-1:0] c_HOLD_LAST = HW'(4 * HOLD_FRAMES - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHOW  = 2'd1;
`ifdef DISP_SCHED_BLANK_EN
    localparam logic [1:0] c_BLANK = 2'd2;
`endif

    logic [PW-1:0] r_pre;
    logic [HW-1:0] r_hold;
    logic [1:0]    r_state;
    logic [15:0]   r_data;
    logic          r_src;
    logic          r_last;
    logic          r_ack0;
    logic          r_ack1;

    logic          w_tick;
    logic          w_any;
    logic          w_win;

    assign w_tick = (r_pre == c_PRE_LAST);
    assign w_any  = req0_valid | req1_valid;
    // On a tie the source that was not granted last wins.
    assign w_win  = (req0_valid & req1_valid) ? ~r_last : req1_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_data  <= 16'h0000;
            r_src   <= 1'b0;
            r_last  <= 1'b1;
            r_hold  <= '0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_state <= c_SHOW;
                        r_data  <= w_win ? req1_data : req0_data;
                        r_src   <= w_win;
                        r_last  <= w_win;
                        r_ack0  <= ~w_win;
                        r_ack1  <= w_win;
                        r_hold  <= '0;
                    end
                end
                c_SHOW: begin
                    if (w_tick) begin
                        if (r_hold == c_HOLD_LAST) begin
                            r_hold  <= '0;
`ifdef DISP_SCHED_BLANK_EN
                            r_state <= c_BLANK;
`else
                            r_state <= c_IDLE;
`endif
                        end else begin
                            r_hold <= r_hold + 1'b1;
                        end
                    end
                end
`ifdef DISP_SCHED_BLANK_EN
                c_BLANK: begin
                    if (w_tick) begin
                        r_state <= c_IDLE;
                    end
                end
`endif
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign disp_src  = r_src;
    assign disp_busy = (r_state == c_SHOW);
    assign scan_tick = w_tick;

`ifdef DISP_SCHED_BLANK_EN
    assign disp_data = (r_state == c_BLANK) ? 16'hFFFF : r_data;
`else
    assign disp_data = r_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_disp_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_sched
// Brief    : Directed self-checking bench for disp_sched (PRESCALE=4,
//            HOLD_FRAMES=1) with an expected-grant scoreboard queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_disp_sched;

    localparam int PRESCALE    = 4;
    localparam int HOLD_FRAMES = 1;
    localparam int WIN_TICKS   = 4 * HOLD_FRAMES;
`ifdef DISP_SCHED_BLANK_EN
    localparam int GAP = PRESCALE + 1;
`else
    localparam int GAP = 1;
`endif

    logic        clk;
    logic        reset;
    logic        req0_valid;
    logic [15:0] req0_data;
    logic        req1_valid;
    logic [15:0] req1_data;
    logic        ack0;
    logic        ack1;
    logic [15:0] disp_data;
    logic        disp_src;
    logic        disp_busy;
    logic        scan_tick;

    disp_sched #(
        .PRESCALE    (PRESCALE),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .ack0       (ack0),
        .ack1       (ack1),
        .disp_data  (disp_data),
        .disp_src   (disp_src),
        .disp_busy  (disp_busy),
        .scan_tick  (scan_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        src;
        logic [15:0] data;
    } grant_t;

    grant_t exp_q[$];

    int   n_vec;
    int   n_err;
    int   cyc;
    int   last_tick_cyc;
    int   win_ticks;
    int   fall_cyc;
    logic prev_busy;
    bit   b2b;
    bit   auto_drop;
    bit   seen_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data"}, disp_data, 16'h0000);
        chk({tag, "_src"},  disp_src,  1'b0);
        chk({tag, "_busy"}, disp_busy, 1'b0);
        chk({tag, "_ack"},  {ack1, ack0}, 2'b00);
        chk({tag, "_tick"}, scan_tick, 1'b0);
    endtask

    // Per-cycle monitor: scoreboard pop on ack plus tick/window/gap checks.
    task automatic monitor();
        grant_t g;
        cyc++;
        seen_ack = 0;
        if (ack0 | ack1) begin
            seen_ack = 1;
            chk("one_ack", ack0 & ack1, 1'b0);
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", {ack1, ack0}, 2'b00);
            end else begin
                g = exp_q.pop_front();
                chk("ack_src", ack1, g.src);
                chk("grant_data", disp_data, g.data);
                chk("grant_src", disp_src, g.src);
                chk("busy_at_grant", disp_busy, 1'b1);
                if (b2b) chk("idle_gap", cyc - fall_cyc, GAP);
            end
            win_ticks = 0;
        end
        if (disp_busy && scan_tick) win_ticks++;
        if (prev_busy && !disp_busy) begin
            fall_cyc = cyc;
            chk("window_ticks", win_ticks, WIN_TICKS);
`ifdef DISP_SCHED_BLANK_EN
            chk("blank_word", disp_data, 16'hFFFF);
`endif
        end
`ifndef DISP_SCHED_BLANK_EN
        chk("no_ffff", disp_data !== 16'hFFFF, 1'b1);
`endif
        if (scan_tick) begin
            if (last_tick_cyc >= 0) chk("tick_period", cyc - last_tick_cyc, PRESCALE);
            last_tick_cyc = cyc;
        end
        if (auto_drop) begin
            if (ack0) req0_valid = 1'b0;
            if (ack1) req1_valid = 1'b0;
        end
        prev_busy = disp_busy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_ack(input string tag, input int max);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!seen_ack && k < max);
        chk({tag, "_ack_in_time"}, seen_ack, 1'b1);
    endtask

    task automatic wait_ticks(input string tag, input int n);
        int k;
        k = 0;
        while (win_ticks < n && k < 40) begin
            step();
            k++;
        end
        chk({tag, "_ticks"}, win_ticks, n);
    endtask

    task automatic wait_end(input string tag);
        int k;
        k = 0;
        while (disp_busy && k < 8 * PRESCALE * HOLD_FRAMES + 8) begin
            step();
            k++;
        end
        chk({tag, "_show_ends"}, disp_busy, 1'b0);
        run(PRESCALE + 2);
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        #1;
        last_tick_cyc = -1;
        prev_busy     = 1'b0;
        win_ticks     = 0;
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; last_tick_cyc = -1;
        win_ticks = 0; fall_cyc = 0; prev_busy = 1'b0;
        b2b = 0; auto_drop = 1; seen_ack = 0;
        reset = 1'b1;
        req0_valid = 1'b0; req0_data = 16'h0000;
        req1_valid = 1'b0; req1_data = 16'h0000;

        // Reset state, then idle with no requests
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        reset = 1'b0;
        run(12);
        chk("idle_data", disp_data, 16'h0000);

        // Single request from source 0
        req0_data = 16'h1234; req0_valid = 1'b1;
        exp_q.push_back('{1'b0, 16'h1234});
        wait_ack("t_single", 1);
        wait_end("t_single");
        chk("idle_keeps_word", disp_data, 16'h1234);
        chk("idle_keeps_src", disp_src, 1'b0);

        // Request withdrawn before grant yields nothing
        req0_data = 16'h1111; req0_valid = 1'b1;
        exp_q.push_back('{1'b0, 16'h1111});
        wait_ack("t_drop", 1);
        run(2);
        req1_data = 16'h2222; req1_valid = 1'b1;
        run(2);
        req1_valid = 1'b0;
        wait_end("t_drop");
        run(10);
        chk("t_drop_queue_empty", exp_q.size(), 0);

        // Source 1 raised mid-window waits for one IDLE cycle
        req0_data = 16'h0F0F; req0_valid = 1'b1;
        exp_q.push_back('{1'b0, 16'h0F0F});
        wait_ack("t_mid", 1);
        wait_ticks("t_mid", 2);
        req1_data = 16'hBEEF; req1_valid = 1'b1;
        exp_q.push_back('{1'b1, 16'hBEEF});
        b2b = 1;
        wait_ack("t_mid_beef", 40);
        b2b = 0;
        wait_end("t_mid");

        // Reset in the middle of a window with a request pending
        req0_data = 16'hC0DE; req0_valid = 1'b1;
        exp_q.push_back('{1'b0, 16'hC0DE});
        wait_ack("t_rst", 1);
        wait_ticks("t_rst", 2);
        req1_data = 16'h7777; req1_valid = 1'b1;
        assert_reset();
        chk_reset_vals("midshow_reset");
        run(3);
        chk_reset_vals("held_reset");
        reset = 1'b0;
        exp_q.push_back('{1'b1, 16'h7777});
        wait_ack("t_rst_release", 1);
        wait_end("t_rst");

        // Fresh reset, then both sources held: 0,1,0,1
        step();
        assert_reset();
        step();
        reset = 1'b0;
        auto_drop = 0;
        req0_data = 16'hAAAA; req1_data = 16'h5555;
        req0_valid = 1'b1; req1_valid = 1'b1;
        exp_q.push_back('{1'b0, 16'hAAAA});
        exp_q.push_back('{1'b1, 16'h5555});
        exp_q.push_back('{1'b0, 16'hAAAA});
        exp_q.push_back('{1'b1, 16'h5555});
        wait_ack("t_rr0", 1);
        b2b = 1;
        wait_ack("t_rr1", 40);
        wait_ack("t_rr2", 40);
        wait_ack("t_rr3", 40);
        req0_valid = 1'b0; req1_valid = 1'b0;
        b2b = 0;
        auto_drop = 1;
        wait_end("t_rr");
        run(8);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/disp_sched.md
DISP_SCHED -- requirements
Module: disp_sched

Interface
REQ-001 Parameter PRESCALE, default 50000, clk cycles per scan_tick pulse (legal range 2..2^20).
REQ-002 Parameter HOLD_FRAMES, default 2, number of 4-digit scan frames a granted word stays on display (legal range 1..255).
REQ-003 clk  input  1  system clock, all state rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0_valid  input  1  source 0 (datapath debug word) requests display.
REQ-006 req0_data  input  16  source 0 word, sampled only at grant.
REQ-007 req1_valid  input  1  source 1 (FSM state monitor) requests display.
REQ-008 req1_data  input  16  source 1 word, sampled only at grant.
REQ-009 ack0, ack1  output  1 each  one-cycle grant pulse to the matching source.
REQ-010 disp_data  output  16  word driven to the digit multiplexer.
REQ-011 disp_src  output  1  source index of the word currently in disp_data.
REQ-012 disp_busy  output  1  high while a hold window is running.
REQ-013 scan_tick  output  1  one-cycle pulse advancing the digit multiplexer by one digit.

Function
REQ-014 Prescaler: free-running counter 0..PRESCALE-1; scan_tick high for exactly one cycle when counter equals PRESCALE-1, then wraps to 0; runs in every state.
REQ-015 States: IDLE, SHOW (plus BLANK per REQ-027); only states reachable.
REQ-016 IDLE: if any reqN_valid high, register the grant at the next edge: enter SHOW, load disp_data/disp_src from the winner, pulse ackN for that one cycle.
REQ-017 Arbitration: round-robin; single valid wins; both valid -> source other than last granted wins; after reset, last-granted pointer = 1 (source 0 wins first tie).
REQ-018 Requester contract: valid held until ack; valid dropped before ack yields no grant and no error.
REQ-019 At most one ack high per cycle; never an ack outside a transition into SHOW.
REQ-020 SHOW: hold counter counts scan_tick pulses from 0; on the pulse making count = 4*HOLD_FRAMES, transition to IDLE (or BLANK) at that edge.
REQ-021 SHOW ignores all requests; disp_data and disp_src constant throughout.
REQ-022 IDLE keeps the last displayed word and source; disp_busy = 1 only in SHOW.
REQ-023 Request arriving in the same cycle SHOW exits: granted on the cycle after IDLE entry (one-cycle IDLE minimum).
REQ-024 Hold counter width sufficient for 4*255; no overflow within legal range.

Reset
REQ-025 On reset: state IDLE, disp_data = 16'h0000, disp_src = 0, disp_busy = 0, ack0 = ack1 = 0, scan_tick = 0, prescaler = 0, hold counter = 0, last-granted pointer = 1.
REQ-026 Reset asserted mid-SHOW aborts the window immediately; no ack issued for any pending request until after deassertion.

Configuration
REQ-027 Macro DISP_SCHED_BLANK_EN defined: SHOW exit goes to BLANK, which forces disp_data = 16'hFFFF for exactly one scan_tick period (exit on next scan_tick), then IDLE; requests ignored in BLANK; disp_busy = 0 in BLANK.
REQ-028 Macro undefined: no BLANK state, SHOW exits directly to IDLE.

Verification (PRESCALE=4, HOLD_FRAMES=1)
REQ-029 Reset, no requests -> scan_tick every 4th cycle, disp_data 16'h0000, no acks.
REQ-030 req0 valid with 16'h1234 -> ack0 one cycle, disp_data 16'h1234, disp_busy high exactly 4 scan_tick pulses, then IDLE.
REQ-031 req0 = 16'hAAAA and req1 = 16'h5555 held together -> grants 0,1,0,1 alternating, each word shown 4 ticks, one IDLE cycle between.
REQ-032 req1 = 16'hBEEF raised mid-SHOW of source 0 -> no ack1 until SHOW ends, then ack1 after one IDLE cycle.
REQ-033 Reset asserted after 2 ticks of SHOW -> all outputs at reset values next cycle; pending request granted after release.
REQ-034 With DISP_SCHED_BLANK_EN -> 16'hFFFF for one tick between consecutive words; without -> never 16'hFFFF unless a source supplies it.
